// File: rtl/set_assoc_cache.sv
// Purpose: read-only set-associative cache with LRU replacement, per-line/global invalidate, refill from next level.
// Latency: hit answers one cycle after acceptance; miss answers the cycle after mem_ack.
// Backpressure: req_ready is high only when idle; requests/invalidates offered while busy are dropped, not queued.
//
// Ports: clk/rst (async active-low); req_valid/req_addr/req_ready read request;
//        inv/inv_addr single-line invalidate, inv_all whole-cache flush;
//        rd_valid/rd_data/hit read response; mem_req/mem_addr/mem_ack/mem_data refill;
//        hit_cnt/miss_cnt saturating statistics.
module set_assoc_cache #(
    parameter int WORD_LEN        = 32,
    parameter int ADDR_LEN        = 15,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int SETS            = 512,
    parameter int WAYS            = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    input  logic [ADDR_LEN-1:0]                 req_addr,
    output logic                                req_ready,
    input  logic                                inv,
    input  logic                                inv_all,
    input  logic [ADDR_LEN-1:0]                 inv_addr,
    output logic                                rd_valid,
    output logic [WORD_LEN-1:0]                 rd_data,
    output logic                                hit,
    output logic                                mem_req,
    output logic [ADDR_LEN-$clog2(WORDS_PER_BLOCK)-1:0] mem_addr,
    input  logic                                mem_ack,
    input  logic [WORD_LEN*WORDS_PER_BLOCK-1:0] mem_data,
    output logic [15:0]                         hit_cnt,
    output logic [15:0]                         miss_cnt
);
    localparam int OFF  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_LEN - IDX - OFF;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE = WORD_LEN * WORDS_PER_BLOCK;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESP, FLUSH} state_t;

    state_t              state, state_nxt;
    logic [ADDR_LEN-1:0] addr_q;
    logic [WW-1:0]       victim_q;
    logic [IDX-1:0]      fidx;

    logic [WAYS-1:0] valid    [SETS];
    logic [WW-1:0]   age      [SETS][WAYS];
    logic [TAG-1:0]  tag_mem  [WAYS][SETS];
    logic [LINE-1:0] data_mem [WAYS][SETS];

    logic [OFF-1:0] off_q;
    logic [IDX-1:0] idx_q;
    logic [TAG-1:0] tag_q;
    logic [IDX-1:0] inv_idx;
    logic [TAG-1:0] inv_tag;
    logic [OFF-1:0] inv_off_unused;

    assign off_q          = addr_q[OFF-1:0];
    assign idx_q          = addr_q[OFF+IDX-1:OFF];
    assign tag_q          = addr_q[ADDR_LEN-1:OFF+IDX];
    assign inv_idx        = inv_addr[OFF+IDX-1:OFF];
    assign inv_tag        = inv_addr[ADDR_LEN-1:OFF+IDX];
    assign inv_off_unused = inv_addr[OFF-1:0];
    assign mem_addr       = addr_q[ADDR_LEN-1:OFF];

    logic            lk_hit;
    logic [WW-1:0]   lk_way;
    logic [WW-1:0]   victim;
    logic            free_found;
    logic [WW-1:0]   free_way;
    logic [WW-1:0]   lru_way;
    logic [WAYS-1:0] inv_match;
    logic [WW-1:0]   acc_way;
    logic            lru_upd;
    logic [LINE-1:0] rd_line;

    logic acc_flush, acc_inv, acc_req;
    assign acc_flush = (state == IDLE) && inv_all;
    assign acc_inv   = (state == IDLE) && !inv_all && inv;
    assign acc_req   = (state == IDLE) && !inv_all && !inv && req_valid;

    always_comb begin
        lk_hit     = 1'b0;
        lk_way     = '0;
        free_found = 1'b0;
        free_way   = '0;
        lru_way    = '0;
        inv_match  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx_q][w] && tag_mem[w][idx_q] == tag_q) begin
                lk_hit = 1'b1;
                lk_way = WW'(w);
            end
            if (age[idx_q][w] == WW'(WAYS - 1))
                lru_way = WW'(w);
            inv_match[w] = valid[inv_idx][w] && (tag_mem[w][inv_idx] == inv_tag);
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[idx_q][w]) begin
                free_found = 1'b1;
                free_way   = WW'(w);
            end
        end
        victim = free_found ? free_way : lru_way;
    end

    assign acc_way = (state == LOOKUP) ? lk_way : victim_q;
    assign lru_upd = ((state == LOOKUP) && lk_hit) || ((state == REFILL) && mem_ack);
    assign rd_line = (state == RESP) ? data_mem[victim_q][idx_q] : data_mem[lk_way][idx_q];

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rd_valid  = 1'b0;
        hit       = 1'b0;
        mem_req   = 1'b0;
        rd_data   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (acc_flush)    state_nxt = FLUSH;
                else if (acc_req) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (lk_hit) begin
                    rd_valid  = 1'b1;
                    hit       = 1'b1;
                    rd_data   = rd_line[off_q*WORD_LEN +: WORD_LEN];
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = RESP;
            end
            RESP: begin
                rd_valid  = 1'b1;
                rd_data   = rd_line[off_q*WORD_LEN +: WORD_LEN];
                state_nxt = IDLE;
            end
            FLUSH: begin
                if (fidx == IDX'(SETS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            fidx     <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (acc_req)   addr_q <= req_addr;
            if (acc_flush) fidx   <= '0;
            if (state == FLUSH) fidx <= fidx + 1'b1;
            if (state == LOOKUP) begin
                if (lk_hit) begin
                    if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                end else begin
                    if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                    victim_q <= victim;
                end
            end
        end
    end

    // Valid bits and LRU ages need reset; tags and data do not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= WW'(w);
            end
        end else begin
            if (acc_inv) begin
                for (int w = 0; w < WAYS; w++)
                    if (inv_match[w]) valid[inv_idx][w] <= 1'b0;
            end
            if (state == FLUSH)
                valid[fidx] <= '0;
            if ((state == REFILL) && mem_ack)
                valid[idx_q][victim_q] <= 1'b1;
            // Accessed way becomes youngest; only ways younger than it shift older.
            if ((WAYS > 1) && lru_upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == acc_way)
                        age[idx_q][w] <= '0;
                    else if (age[idx_q][w] < age[idx_q][acc_way])
                        age[idx_q][w] <= age[idx_q][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == REFILL) && mem_ack) begin
            tag_mem[victim_q][idx_q]  <= tag_q;
            data_mem[victim_q][idx_q] <= mem_data;
        end
    end
endmodule
